glitch_detector: RTL and testbench

GLITCH_DETECTOR -- requirements
Module: glitch_detector

---
 rtl/glitch_detector.sv | 177 +++++++++++++++++
 tb/tb_glitch_detector.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glitch_detector.sv
// glitch_detector: synchronizes an asynchronous pulse train, measures the width
// of every completed phase in clk cycles and flags phases shorter than MIN_TICKS.
// Optional build macro GLITCH_DET_STUCK_EN enables the MAX_TICKS stuck timeout;
// without it stuck is tied low and the phase counter only saturates.
module glitch_detector #(
    parameter int unsigned MIN_TICKS = 20,
    parameter int unsigned MAX_TICKS = 4000,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clear,
    output logic             glitch,
    output logic [CNT_W-1:0] glitch_count,
    output logic [CNT_W-1:0] last_width,
    output logic             width_valid,
    output logic             level,
    output logic             stuck
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    logic             sync1_q;
    logic             sync2_q;
    logic             edge_mem_q;
    logic             edge_det_c;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] last_width_q, last_width_d;
    logic             level_q, level_d;
    logic             width_valid_q, width_valid_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] glitch_count_q, glitch_count_d;

    logic [31:0]      cnt_wide_c;
    logic             short_c;
    logic [CNT_W-1:0] cnt_inc_c;
    logic [CNT_W-1:0] gcnt_inc_c;

`ifdef GLITCH_DET_STUCK_EN
    logic             stuck_q, stuck_d;
    logic             timeout_c;
`else
    logic [31:0]      unused_max_ticks;
`endif

    // Two-flop synchronizer followed by the edge-memory flop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_mem_q <= 1'b0;
        end else begin
            sync1_q    <= sig_in;
            sync2_q    <= sync1_q;
            edge_mem_q <= sync2_q;
        end
    end

    assign edge_det_c = sync2_q ^ edge_mem_q;
    assign cnt_wide_c = 32'(cnt_q);
    assign short_c    = cnt_wide_c < MIN_TICKS;
    assign cnt_inc_c  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign gcnt_inc_c = (glitch_count_q == CNT_MAX) ? glitch_count_q
                                                    : glitch_count_q + CNT_ONE;

`ifdef GLITCH_DET_STUCK_EN
    assign timeout_c = cnt_wide_c >= MAX_TICKS;
`else
    // Timeout is compiled out; the parameter stays for a uniform interface
    assign unused_max_ticks = 32'(MAX_TICKS);
`endif

    // State and measurement registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            last_width_q   <= '0;
            level_q        <= 1'b0;
            width_valid_q  <= 1'b0;
            glitch_q       <= 1'b0;
            glitch_count_q <= '0;
`ifdef GLITCH_DET_STUCK_EN
            stuck_q        <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            last_width_q   <= last_width_d;
            level_q        <= level_d;
            width_valid_q  <= width_valid_d;
            glitch_q       <= glitch_d;
            glitch_count_q <= glitch_count_d;
`ifdef GLITCH_DET_STUCK_EN
            stuck_q        <= stuck_d;
`endif
        end
    end

    // Next-state: phase tracking, width report, glitch counting, clear
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        last_width_d   = last_width_q;
        level_d        = level_q;
        width_valid_d  = 1'b0;
        glitch_d       = 1'b0;
        glitch_count_d = glitch_count_q;
`ifdef GLITCH_DET_STUCK_EN
        stuck_d        = stuck_q;
`endif

        case (state_q)
            IDLE: begin
                // First edge only establishes the phase; nothing to report yet
                if (edge_det_c) begin
                    state_d = sync2_q ? HIGH : LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            HIGH, LOW: begin
                if (edge_det_c) begin
                    last_width_d  = cnt_q;
                    level_d       = (state_q == HIGH);
                    width_valid_d = 1'b1;
                    state_d       = (state_q == HIGH) ? LOW : HIGH;
                    cnt_d         = CNT_ONE;
                    if (short_c) begin
                        glitch_d       = 1'b1;
                        glitch_count_d = gcnt_inc_c;
                    end
`ifdef GLITCH_DET_STUCK_EN
                end else if (timeout_c) begin
                    // A phase ending exactly at MAX_TICKS is still reported
                    stuck_d = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Clear beats a coincident glitch increment or timeout
        if (clear) begin
            glitch_count_d = '0;
`ifdef GLITCH_DET_STUCK_EN
            stuck_d        = 1'b0;
`endif
        end
    end

    assign glitch       = glitch_q;
    assign glitch_count = glitch_count_q;
    assign last_width   = last_width_q;
    assign width_valid  = width_valid_q;
    assign level        = level_q;
`ifdef GLITCH_DET_STUCK_EN
    assign stuck        = stuck_q;
`else
    assign stuck        = 1'b0;
`endif

endmodule

// File: tb/tb_glitch_detector.sv
// tb_glitch_detector: three glitch_detector configurations share one stimulus
// stream; a phase-level reference model predicts every output each cycle.
module tb_glitch_detector;

    localparam int NI    = 3;
    localparam int MIN_T = 20;
`ifdef GLITCH_DET_STUCK_EN
    localparam bit STUCK_EN = 1'b1;
`else
    localparam bit STUCK_EN = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic sig_in;
    logic clear;

    logic        a_gl, a_wv, a_lvl, a_stuck;
    logic [15:0] a_gcnt, a_last;
    logic        b_gl, b_wv, b_lvl, b_stuck;
    logic [3:0]  b_gcnt, b_last;
    logic        c_gl, c_wv, c_lvl, c_stuck;
    logic [15:0] c_gcnt, c_last;

    glitch_detector #(.MIN_TICKS(20), .MAX_TICKS(4000), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clear(clear),
        .glitch(a_gl), .glitch_count(a_gcnt), .last_width(a_last),
        .width_valid(a_wv), .level(a_lvl), .stuck(a_stuck)
    );

    glitch_detector #(.MIN_TICKS(20), .MAX_TICKS(4000), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clear(clear),
        .glitch(b_gl), .glitch_count(b_gcnt), .last_width(b_last),
        .width_valid(b_wv), .level(b_lvl), .stuck(b_stuck)
    );

    glitch_detector #(.MIN_TICKS(20), .MAX_TICKS(100), .CNT_W(16)) dut_c (
        .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .clear(clear),
        .glitch(c_gl), .glitch_count(c_gcnt), .last_width(c_last),
        .width_valid(c_wv), .level(c_lvl), .stuck(c_stuck)
    );

    // Observed outputs gathered per instance
    logic        obs_wv    [NI];
    logic        obs_gl    [NI];
    logic        obs_lvl   [NI];
    logic        obs_stuck [NI];
    logic [15:0] obs_last  [NI];
    logic [15:0] obs_gcnt  [NI];

    assign obs_wv[0] = a_wv;  assign obs_gl[0] = a_gl;  assign obs_lvl[0] = a_lvl;
    assign obs_wv[1] = b_wv;  assign obs_gl[1] = b_gl;  assign obs_lvl[1] = b_lvl;
    assign obs_wv[2] = c_wv;  assign obs_gl[2] = c_gl;  assign obs_lvl[2] = c_lvl;
    assign obs_stuck[0] = a_stuck; assign obs_stuck[1] = b_stuck; assign obs_stuck[2] = c_stuck;
    assign obs_last[0] = a_last;   assign obs_last[1] = 16'(b_last); assign obs_last[2] = c_last;
    assign obs_gcnt[0] = a_gcnt;   assign obs_gcnt[1] = 16'(b_gcnt); assign obs_gcnt[2] = c_gcnt;

    function automatic int max_of(input int i);
        return (i == 2) ? 100 : 4000;
    endfunction

    function automatic int sat_of(input int i);
        return (i == 1) ? 15 : 65535;
    endfunction

    // Reference model: phases as driven, reports due two iterations later
    typedef struct {
        int   due;
        int   inst;
        int   width;
        logic lvl;
        logic gl;
    } rep_t;

    rep_t rep_q[$];
    int   t;
    logic cur_lvl;
    int   cur_len;
    bit   armed;
    int   stk_cur [NI];
    int   stk_old [NI];
    logic exp_wv    [NI];
    logic exp_gl    [NI];
    logic exp_lvl   [NI];
    logic exp_stuck [NI];
    int   exp_last  [NI];
    int   exp_gcnt  [NI];

    int n_pass;
    int n_fail;
    int n_checks;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        rep_q.delete();
        armed   = 1'b0;
        cur_lvl = 1'b0;
        cur_len = 0;
        for (int i = 0; i < NI; i++) begin
            stk_cur[i]   = -1;
            stk_old[i]   = -1;
            exp_wv[i]    = 1'b0;
            exp_gl[i]    = 1'b0;
            exp_lvl[i]   = 1'b0;
            exp_stuck[i] = 1'b0;
            exp_last[i]  = 0;
            exp_gcnt[i]  = 0;
        end
    endtask

    task automatic model_drive(input logic lvl);
        int w;
        if (lvl !== cur_lvl) begin
            for (int i = 0; i < NI; i++) begin
                if (armed) begin
                    if (STUCK_EN && cur_len > max_of(i)) begin
                        stk_old[i] = stk_cur[i];
                    end else begin
                        w = (cur_len > sat_of(i)) ? sat_of(i) : cur_len;
                        rep_q.push_back('{due: t + 2, inst: i, width: w,
                                          lvl: cur_lvl, gl: (w < MIN_T)});
                    end
                end
                stk_cur[i] = STUCK_EN ? t + max_of(i) + 2 : -1;
            end
            armed   = 1'b1;
            cur_lvl = lvl;
            cur_len = 1;
        end else begin
            cur_len++;
        end
    endtask

    task automatic model_check(input logic clr);
        rep_t r;
        for (int i = 0; i < NI; i++) begin
            exp_wv[i] = 1'b0;
            exp_gl[i] = 1'b0;
        end
        while (rep_q.size() > 0 && rep_q[0].due == t) begin
            r = rep_q.pop_front();
            exp_wv[r.inst]   = 1'b1;
            exp_last[r.inst] = r.width;
            exp_lvl[r.inst]  = r.lvl;
            if (r.gl) begin
                exp_gl[r.inst] = 1'b1;
                if (exp_gcnt[r.inst] < sat_of(r.inst)) exp_gcnt[r.inst]++;
            end
        end
        for (int i = 0; i < NI; i++) begin
            if (stk_cur[i] == t || stk_old[i] == t) exp_stuck[i] = 1'b1;
            if (clr) begin
                exp_gcnt[i]  = 0;
                exp_stuck[i] = 1'b0;
            end
        end
    endtask

    task automatic chk(input string tag, input int inst, input logic [15:0] obs,
                       input logic [15:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s dut%0d t=%0d: got %0h expected %0h", tag, inst, t, obs, expv);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NI; i++) begin
            chk("width_valid",  i, 16'(obs_wv[i]),    16'(exp_wv[i]));
            chk("glitch",       i, 16'(obs_gl[i]),    16'(exp_gl[i]));
            chk("level",        i, 16'(obs_lvl[i]),   16'(exp_lvl[i]));
            chk("stuck",        i, 16'(obs_stuck[i]), 16'(exp_stuck[i]));
            chk("last_width",   i, obs_last[i],       16'(exp_last[i]));
            chk("glitch_count", i, obs_gcnt[i],       16'(exp_gcnt[i]));
        end
    endtask

    // One clock of stimulus, then check at the following falling edge
    task automatic step(input logic lvl, input logic clr);
        sig_in = lvl;
        clear  = clr;
        if (rst_n) model_drive(lvl);
        @(negedge clk);
        if (rst_n) model_check(clr);
        else model_reset();
        compare_all();
        t++;
    endtask

    task automatic hold(input logic lvl, input int n);
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
    endtask

    task automatic reset_cycles(input int n, input logic lvl);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step(lvl, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic lv;
        int   len;
        n_pass   = 0;
        n_fail   = 0;
        n_checks = 0;
        t        = 0;
        rst_n    = 1'b0;
        sig_in   = 1'b0;
        clear    = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset state
        reset_cycles(4, 1'b0);

        // Clean 150-cycle phases, a 10-cycle glitch, an exactly-legal 20-cycle pulse
        hold(1'b1, 150);
        hold(1'b0, 150);
        hold(1'b1, 150);
        hold(1'b0, 150);
        hold(1'b1, 10);
        hold(1'b0, 150);
        hold(1'b1, 20);
        hold(1'b0, 40);

        // Very short phases, around the MIN_TICKS boundary
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 2);
        hold(1'b0, 3);
        hold(1'b1, 19);
        hold(1'b0, 21);
        hold(1'b1, 30);

        // Burst of glitches to saturate the 4-bit counter
        lv = 1'b1;
        for (int k = 0; k < 20; k++) begin
            lv = ~lv;
            hold(lv, 3);
        end
        // Clear lands on the same edge as the next glitch report
        lv = ~lv;
        step(lv, 1'b0);
        step(lv, 1'b0);
        step(lv, 1'b1);
        hold(lv, 30);

        // Randomized phases with occasional clear
        for (int k = 0; k < 60; k++) begin
            lv  = ~lv;
            len = int'($urandom_range(1, 45));
            for (int j = 0; j < len; j++) step(lv, ($urandom_range(0, 49) == 0));
        end

        // Long hold past MAX_TICKS, following edge, then clear
        if (lv == 1'b1) hold(1'b0, 30);
        hold(1'b1, 300);
        hold(1'b0, 50);
        step(1'b0, 1'b1);
        hold(1'b0, 20);
        hold(1'b1, 30);

        // Reset pulse in the middle of a phase
        hold(1'b0, 30);
        hold(1'b1, 50);
        reset_cycles(3, 1'b1);
        hold(1'b1, 40);
        hold(1'b0, 30);
        hold(1'b1, 25);
        hold(1'b0, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
